// File: rtl/display_msg_scheduler.sv
// Message arbiter for the 4-digit multiplexed coffee-machine display.
// Picks standby, a selection (CE01/CL02/CC05/CP10) or an error
// (ERSR/ERSP/ERSN/ERDI), holds each shown message for a minimum time,
// rotates through simultaneous errors and generates the digit-scan strobe.
module display_msg_scheduler #(
  parameter int SCAN_DIV    = 4,
  parameter int HOLD_CYCLES = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] sel_req,
  input  logic [3:0] err_req,
  output logic [3:0] msg_code,
  output logic       msg_change,
  output logic [1:0] digit,
  output logic [3:0] digit_en
);

  localparam int TW = $clog2(HOLD_CYCLES);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHOW_SEL = 2'd1,
    SHOW_ERR = 2'd2
  } state_t;

  // First set request bit searching upward from last+1 with wrap-around.
  function automatic logic [1:0] err_pick(input logic [3:0] req, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] cand;
    logic       found;
    idx   = last;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = last + 2'(k);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end else begin
        idx   = idx;
      end
    end
    return idx;
  endfunction

  // Lowest set request bit (fixed priority, S0 highest).
  function automatic logic [1:0] sel_pick(input logic [3:0] req);
    logic [1:0] idx;
    idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (req[k]) begin
        idx = 2'(k);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Scan registers
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    digit_q, digit_d;
  logic [3:0]    digit_en_q;

  // Arbiter registers
  state_t        state_q, state_d;
  logic [3:0]    msg_code_q, msg_code_d;
  logic          msg_change_q, msg_change_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    rr_q, rr_d;

  logic [1:0]    err_idx_s;
  logic [1:0]    sel_idx_s;
  logic [1:0]    cur_sel_s;
  logic [3:0]    err_code_s;
  logic [3:0]    sel_code_s;

  // Prescaler wraps at SCAN_DIV-1 and advances the scanned digit on that cycle.
  always_comb begin
    presc_d = presc_q;
    digit_d = digit_q;
    if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      digit_d = digit_q + 2'd1;
    end else begin
      presc_d = presc_q + PW'(1);
      digit_d = digit_q;
    end
  end

  // Scan state; digit_en is decoded from the next digit so it never lags digit.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      presc_q    <= '0;
      digit_q    <= 2'd0;
      digit_en_q <= 4'b0001;
    end else begin
      presc_q    <= presc_d;
      digit_q    <= digit_d;
      digit_en_q <= 4'b0001 << digit_d;
    end
  end

  // Request picks and the message codes they map to.
  always_comb begin
    err_idx_s  = err_pick(err_req, rr_q);
    sel_idx_s  = sel_pick(sel_req);
    err_code_s = 4'd5 + {2'b00, err_idx_s};
    sel_code_s = 4'd1 + {2'b00, sel_idx_s};
    // Codes 1..4 have low bits 01,10,11,00; minus one gives the selection index.
    cur_sel_s  = msg_code_q[1:0] - 2'd1;
  end

  // Next-state arbitration: errors preempt selections, errors are never preempted.
  always_comb begin
    state_d    = state_q;
    msg_code_d = msg_code_q;
    rr_d       = rr_q;
    if (timer_q != '0) begin
      timer_d = timer_q - TW'(1);
    end else begin
      timer_d = timer_q;
    end
    case (state_q)
      IDLE: begin
        if (err_req != 4'd0) begin
          state_d    = SHOW_ERR;
          msg_code_d = err_code_s;
          timer_d    = HOLD_LOAD;
          rr_d       = err_idx_s;
        end else if (sel_req != 4'd0) begin
          state_d    = SHOW_SEL;
          msg_code_d = sel_code_s;
          timer_d    = HOLD_LOAD;
        end else begin
          state_d    = IDLE;
          msg_code_d = 4'd0;
        end
      end
      SHOW_SEL: begin
        if (err_req != 4'd0) begin
          state_d    = SHOW_ERR;
          msg_code_d = err_code_s;
          timer_d    = HOLD_LOAD;
          rr_d       = err_idx_s;
        end else if (timer_q != '0) begin
          state_d    = SHOW_SEL;
        end else if (sel_req[cur_sel_s]) begin
          // Still requested: keep showing it without a reload.
          state_d    = SHOW_SEL;
        end else if (sel_req != 4'd0) begin
          msg_code_d = sel_code_s;
          timer_d    = HOLD_LOAD;
        end else begin
          state_d    = IDLE;
          msg_code_d = 4'd0;
        end
      end
      SHOW_ERR: begin
        if (timer_q != '0) begin
          state_d    = SHOW_ERR;
        end else if (err_req != 4'd0) begin
          // Re-pick may land on the same code; msg_change then stays low.
          msg_code_d = err_code_s;
          timer_d    = HOLD_LOAD;
          rr_d       = err_idx_s;
        end else if (sel_req != 4'd0) begin
          state_d    = SHOW_SEL;
          msg_code_d = sel_code_s;
          timer_d    = HOLD_LOAD;
        end else begin
          state_d    = IDLE;
          msg_code_d = 4'd0;
        end
      end
      default: begin
        state_d    = IDLE;
        msg_code_d = 4'd0;
        timer_d    = '0;
      end
    endcase
    msg_change_d = (msg_code_d != msg_code_q);
  end

  // Arbiter state and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      msg_code_q   <= 4'd0;
      msg_change_q <= 1'b0;
      timer_q      <= '0;
      rr_q         <= 2'd3;
    end else begin
      state_q      <= state_d;
      msg_code_q   <= msg_code_d;
      msg_change_q <= msg_change_d;
      timer_q      <= timer_d;
      rr_q         <= rr_d;
    end
  end

  assign msg_code   = msg_code_q;
  assign msg_change = msg_change_q;
  assign digit      = digit_q;
  assign digit_en   = digit_en_q;

endmodule

// File: tb/tb_display_msg_scheduler.sv
// Self-checking bench for display_msg_scheduler (SCAN_DIV=4, HOLD_CYCLES=16).
// Expected msg_code/msg_change values are queued as stimulus is driven for an
// edge and popped after that edge.
module tb_display_msg_scheduler;

  logic       CLK;
  logic       RST;
  logic [3:0] sel_req;
  logic [3:0] err_req;
  logic [3:0] msg_code;
  logic       msg_change;
  logic [1:0] digit;
  logic [3:0] digit_en;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_code_q[$];
  logic       exp_chg_q[$];

  display_msg_scheduler #(.SCAN_DIV(4), .HOLD_CYCLES(16)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .sel_req   (sel_req),
    .err_req   (err_req),
    .msg_code  (msg_code),
    .msg_change(msg_change),
    .digit     (digit),
    .digit_en  (digit_en)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // Reset held over two edges, released 1 time unit after an edge.
  task automatic apply_reset();
    RST     = 1'b1;
    sel_req = 4'd0;
    err_req = 4'd0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic test_reset();
    logic [1:0] ed;
    RST = 1'b1; sel_req = 4'd0; err_req = 4'd0;
    repeat (2) @(posedge CLK);
    #1;
    checks++; if (msg_code !== 4'd0) begin errors++; $display("FAIL rst_code: got %0d expected 0", msg_code); end
    checks++; if (msg_change !== 1'b0) begin errors++; $display("FAIL rst_change: got %0b expected 0", msg_change); end
    checks++; if (digit !== 2'd0) begin errors++; $display("FAIL rst_digit: got %0d expected 0", digit); end
    checks++; if (digit_en !== 4'b0001) begin errors++; $display("FAIL rst_digit_en: got %b expected 0001", digit_en); end
    RST = 1'b0;
    err_req = 4'b0001;
    @(posedge CLK); #1;
    @(posedge CLK); #3;
    checks++; if (msg_code !== 4'd5) begin errors++; $display("FAIL pre_rst_code: got %0d expected 5", msg_code); end
    RST = 1'b1;
    #1;
    checks++; if (msg_code !== 4'd0) begin errors++; $display("FAIL async_rst_code: got %0d expected 0", msg_code); end
    checks++; if (msg_change !== 1'b0) begin errors++; $display("FAIL async_rst_change: got %0b expected 0", msg_change); end
    checks++; if (digit !== 2'd0) begin errors++; $display("FAIL async_rst_digit: got %0d expected 0", digit); end
    checks++; if (digit_en !== 4'b0001) begin errors++; $display("FAIL async_rst_digit_en: got %b expected 0001", digit_en); end
    err_req = 4'd0;
    @(posedge CLK); #1;
    RST = 1'b0;
    for (int s = 1; s <= 17; s++) begin
      @(posedge CLK); #1;
      ed = 2'((s / 4) % 4);
      checks++; if (digit !== ed) begin errors++; $display("FAIL scan_digit step %0d: got %0d expected %0d", s, digit, ed); end
      checks++; if (digit_en !== (4'b0001 << ed)) begin errors++; $display("FAIL scan_digit_en step %0d: got %b expected %b", s, digit_en, 4'b0001 << ed); end
    end
  endtask

  task automatic test_single_sel();
    logic [3:0] ec; logic ech;
    apply_reset();
    for (int s = 1; s <= 18; s++) begin
      sel_req = (s == 1) ? 4'b0010 : 4'b0000;
      exp_code_q.push_back((s <= 16) ? 4'd2 : 4'd0);
      exp_chg_q.push_back(s == 1 || s == 17);
      @(posedge CLK); #1;
      ec = exp_code_q.pop_front(); ech = exp_chg_q.pop_front();
      checks++; if (msg_code !== ec) begin errors++; $display("FAIL single_sel_code step %0d: got %0d expected %0d", s, msg_code, ec); end
      checks++; if (msg_change !== ech) begin errors++; $display("FAIL single_sel_change step %0d: got %0b expected %0b", s, msg_change, ech); end
    end
  endtask

  task automatic test_err_preempt();
    logic [3:0] ec; logic ech;
    apply_reset();
    sel_req = 4'b0001;
    for (int s = 1; s <= 24; s++) begin
      err_req = (s == 6) ? 4'b0100 : 4'b0000;
      exp_code_q.push_back((s >= 6 && s <= 21) ? 4'd7 : 4'd1);
      exp_chg_q.push_back(s == 1 || s == 6 || s == 22);
      @(posedge CLK); #1;
      ec = exp_code_q.pop_front(); ech = exp_chg_q.pop_front();
      checks++; if (msg_code !== ec) begin errors++; $display("FAIL preempt_code step %0d: got %0d expected %0d", s, msg_code, ec); end
      checks++; if (msg_change !== ech) begin errors++; $display("FAIL preempt_change step %0d: got %0b expected %0b", s, msg_change, ech); end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] ec; logic ech; logic [3:0] seq [3];
    seq[0] = 4'd5; seq[1] = 4'd6; seq[2] = 4'd8;
    apply_reset();
    err_req = 4'b1011;
    for (int s = 1; s <= 52; s++) begin
      exp_code_q.push_back(seq[((s - 1) / 16) % 3]);
      exp_chg_q.push_back(((s - 1) % 16) == 0);
      @(posedge CLK); #1;
      ec = exp_code_q.pop_front(); ech = exp_chg_q.pop_front();
      checks++; if (msg_code !== ec) begin errors++; $display("FAIL rr_code step %0d: got %0d expected %0d", s, msg_code, ec); end
      checks++; if (msg_change !== ech) begin errors++; $display("FAIL rr_change step %0d: got %0b expected %0b", s, msg_change, ech); end
    end
  endtask

  task automatic test_hold_deassert();
    logic [3:0] ec; logic ech;
    apply_reset();
    for (int s = 1; s <= 20; s++) begin
      err_req = (s <= 2) ? 4'b0001 : 4'b0000;
      exp_code_q.push_back((s <= 16) ? 4'd5 : 4'd0);
      exp_chg_q.push_back(s == 1 || s == 17);
      @(posedge CLK); #1;
      ec = exp_code_q.pop_front(); ech = exp_chg_q.pop_front();
      checks++; if (msg_code !== ec) begin errors++; $display("FAIL hold_code step %0d: got %0d expected %0d", s, msg_code, ec); end
      checks++; if (msg_change !== ech) begin errors++; $display("FAIL hold_change step %0d: got %0b expected %0b", s, msg_change, ech); end
    end
  endtask

  task automatic test_same_code();
    logic [3:0] ec; logic ech;
    apply_reset();
    for (int s = 1; s <= 50; s++) begin
      err_req = (s <= 40) ? 4'b1000 : 4'b0000;
      exp_code_q.push_back((s <= 48) ? 4'd8 : 4'd0);
      exp_chg_q.push_back(s == 1 || s == 49);
      @(posedge CLK); #1;
      ec = exp_code_q.pop_front(); ech = exp_chg_q.pop_front();
      checks++; if (msg_code !== ec) begin errors++; $display("FAIL same_code step %0d: got %0d expected %0d", s, msg_code, ec); end
      checks++; if (msg_change !== ech) begin errors++; $display("FAIL same_change step %0d: got %0b expected %0b", s, msg_change, ech); end
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] ec; logic ech;
    apply_reset();
    sel_req = 4'b0100;
    err_req = 4'b0010;
    for (int s = 1; s <= 20; s++) begin
      exp_code_q.push_back(4'd6);
      exp_chg_q.push_back(s == 1);
      @(posedge CLK); #1;
      ec = exp_code_q.pop_front(); ech = exp_chg_q.pop_front();
      checks++; if (msg_code !== ec) begin errors++; $display("FAIL simul_code step %0d: got %0d expected %0d", s, msg_code, ec); end
      checks++; if (msg_change !== ech) begin errors++; $display("FAIL simul_change step %0d: got %0b expected %0b", s, msg_change, ech); end
    end
  endtask

  task automatic test_sel_switch();
    logic [3:0] ec; logic ech;
    apply_reset();
    for (int s = 1; s <= 36; s++) begin
      sel_req = (s == 1) ? 4'b0001 : 4'b1100;
      exp_code_q.push_back((s <= 16) ? 4'd1 : 4'd3);
      exp_chg_q.push_back(s == 1 || s == 17);
      @(posedge CLK); #1;
      ec = exp_code_q.pop_front(); ech = exp_chg_q.pop_front();
      checks++; if (msg_code !== ec) begin errors++; $display("FAIL switch_code step %0d: got %0d expected %0d", s, msg_code, ec); end
      checks++; if (msg_change !== ech) begin errors++; $display("FAIL switch_change step %0d: got %0b expected %0b", s, msg_change, ech); end
    end
  endtask

  initial begin
    RST = 1'b1;
    sel_req = 4'd0;
    err_req = 4'd0;
    test_reset();
    test_single_sel();
    test_err_preempt();
    test_round_robin();
    test_hold_deassert();
    test_same_code();
    test_simultaneous();
    test_sel_switch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
